// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ARMv4 ALU.
// Opcode values follow the ARM data-processing encoding.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    function automatic logic is_compare(opcode_e op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Shift-and-add multiplier: one multiplier bit per cycle, optional accumulate.
// done is asserted during the final step; product then carries the completed value.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             acc,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, prod_q;
    logic [WIDTH-1:0] prod_d;

    assign prod_d  = prod_q + (b_sh_q[0] ? a_sh_q : '0);
    assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product = prod_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            prod_q <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            a_sh_q <= a;
            b_sh_q <= b;
            prod_q <= acc ? c : '0;
        end else if (busy_q) begin
            prod_q <= prod_d;
            a_sh_q <= a_sh_q << 1;
            b_sh_q <= b_sh_q >> 1;
            cnt_q  <= cnt_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ARMv4 ALU: data-processing ops in one cycle, MUL/MLA iteratively,
// with the CNVZ flag register updated only on result-load edges.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             mul,
    input  logic             acc,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags_o
);
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       flags_q, flags_d;
    logic             mul_s_q, mul_s_d;

    opcode_e          op_e;
    logic             accept, mul_done, is_arith, cin;
    logic [WIDTH-1:0] x, y, logic_res, alu_res, mul_product;
    logic [WIDTH:0]   sum;
    logic [3:0]       flags_alu;

    assign op_e     = opcode_e'(op);
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && mul),
        .a       (a),
        .b       (b),
        .c       (c),
        .acc     (acc),
        .done    (mul_done),
        .product (mul_product)
    );

    // Every subtract is an add of the inverted operand; carry then means NOT borrow.
    always_comb begin
        x        = a;
        y        = b;
        cin      = 1'b0;
        is_arith = 1'b1;
        case (op_e)
            OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
            OP_ADD, OP_CMN: cin = 1'b0;
            OP_ADC:         cin = flags_q[FLAG_C];
            OP_SBC:         begin y = ~b; cin = flags_q[FLAG_C]; end
            OP_RSC:         begin x = b; y = ~a; cin = flags_q[FLAG_C]; end
            default:        is_arith = 1'b0;
        endcase

        case (op_e)
            OP_AND, OP_TST: logic_res = a & b;
            OP_EOR, OP_TEQ: logic_res = a ^ b;
            OP_ORR:         logic_res = a | b;
            OP_MOV:         logic_res = b;
            OP_BIC:         logic_res = a & ~b;
            OP_MVN:         logic_res = ~b;
            default:        logic_res = '0;
        endcase

        sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;

        flags_alu         = flags_q;
        flags_alu[FLAG_N] = alu_res[WIDTH-1];
        flags_alu[FLAG_Z] = (alu_res == '0);
        if (is_arith) begin
            flags_alu[FLAG_C] = sum[WIDTH];
            flags_alu[FLAG_V] = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        wr_en_d     = wr_en_q;
        flags_d     = flags_q;
        mul_s_d     = mul_s_q;
        case (state_q)
            IDLE: begin
                if (accept && !mul) begin
                    result_d    = alu_res;
                    wr_en_d     = !is_compare(op_e);
                    out_valid_d = 1'b1;
                    if (is_compare(op_e) || set_flags) flags_d = flags_alu;
                end else begin
                    if (out_valid_q && out_ready) out_valid_d = 1'b0;
                    if (accept) begin
                        state_d = MUL;
                        mul_s_d = set_flags;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    result_d    = mul_product;
                    wr_en_d     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    if (mul_s_q) begin
                        flags_d[FLAG_N] = mul_product[WIDTH-1];
                        flags_d[FLAG_Z] = (mul_product == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wr_en_q     <= 1'b0;
            flags_q     <= '0;
            mul_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            wr_en_q     <= wr_en_d;
            flags_q     <= flags_d;
            mul_s_q     <= mul_s_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign wr_en     = wr_en_q;
    assign flags_o   = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8: directed cases plus randomized ops,
// checked against an integer-arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [3:0]   op = '0;
    logic         mul = 1'b0, acc = 1'b0, set_flags = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic         out_valid, out_ready = 1'b1, wr_en;
    logic [W-1:0] result;
    logic [3:0]   flags_o;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .mul(mul), .acc(acc), .set_flags(set_flags),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .wr_en(wr_en), .flags_o(flags_o)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         wr;
        logic [3:0]   fl;
    } exp_t;

    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         bp_mode = 0;
    logic [3:0] mflags = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned/signed views of the operands.
    task automatic push_model(logic [3:0] o, logic m, logic ac, logic s,
                              logic [W-1:0] va, logic [W-1:0] vb, logic [W-1:0] vc);
        int ia, ib, sa, sb, full, sfull, r, ci;
        bit arith, cy, cmp;
        logic [W-1:0] res;
        exp_t e;
        ia = int'(va); ib = int'(vb);
        sa = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
        sb = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
        ci = int'(mflags[FLAG_C]);
        arith = 0; cy = 0; full = 0; sfull = 0; r = 0;
        if (m) begin
            r = ia * ib + (ac ? int'(vc) : 0);
        end else begin
            case (o)
                4'd0, 4'd8:  r = ia & ib;
                4'd1, 4'd9:  r = ia ^ ib;
                4'd12:       r = ia | ib;
                4'd13:       r = ib;
                4'd14:       r = ia & ~ib;
                4'd15:       r = ~ib;
                4'd4, 4'd11: begin arith = 1; full = ia + ib;      sfull = sa + sb;      cy = full >= (1 << W); end
                4'd5:        begin arith = 1; full = ia + ib + ci; sfull = sa + sb + ci; cy = full >= (1 << W); end
                4'd2, 4'd10: begin arith = 1; full = ia - ib;            sfull = sa - sb;            cy = full >= 0; end
                4'd3:        begin arith = 1; full = ib - ia;            sfull = sb - sa;            cy = full >= 0; end
                4'd6:        begin arith = 1; full = ia - ib - (1 - ci); sfull = sa - sb - (1 - ci); cy = full >= 0; end
                default:     begin arith = 1; full = ib - ia - (1 - ci); sfull = sb - sa - (1 - ci); cy = full >= 0; end
            endcase
            if (arith) r = full;
        end
        res = W'(r & MASK);
        cmp = !m && (o >= 4'd8) && (o <= 4'd11);
        if (cmp || s) begin
            mflags[FLAG_N] = res[W-1];
            mflags[FLAG_Z] = (res == '0);
            if (arith) begin
                mflags[FLAG_C] = cy;
                mflags[FLAG_V] = (sfull > (1 << (W-1)) - 1) || (sfull < -(1 << (W-1)));
            end
        end
        e.res = res;
        e.wr  = !cmp;
        e.fl  = mflags;
        sbq.push_back(e);
    endtask

    // Returns at #1 after the accept edge.
    task automatic issue(logic [3:0] o, logic m, logic ac, logic s,
                         logic [W-1:0] va, logic [W-1:0] vb, logic [W-1:0] vc);
        bit done;
        done = 0;
        @(negedge clk);
        op = o; mul = m; acc = ac; set_flags = s; a = va; b = vb; c = vc;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) begin
                push_model(o, m, ac, s, va, vb, vc);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected an accept within 200 cycles");
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [4];
        corner[0] = '0; corner[1] = W'(MASK >> 1); corner[2] = W'(1 << (W-1)); corner[3] = W'(MASK);
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    logic         held = 1'b0;
    logic [W-1:0] h_res;
    logic         h_wr;
    logic [3:0]   h_fl;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held) begin
                check("hold_result", 32'(result), 32'(h_res));
                check("hold_wr_en", 32'(wr_en), 32'(h_wr));
                check("hold_flags", 32'(flags_o), 32'(h_fl));
                check("hold_in_ready", 32'(in_ready), 32'(out_ready));
            end
            if (out_ready) begin
                held = 1'b0;
                if (sbq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_result: got result 0x%0h, expected no output", result);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.wr) check("result", 32'(result), 32'(mon_e.res));
                    check("wr_en", 32'(wr_en), 32'(mon_e.wr));
                    check("flags", 32'(flags_o), 32'(mon_e.fl));
                end
            end else begin
                held  = 1'b1;
                h_res = result; h_wr = wr_en; h_fl = flags_o;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic drain();
        int k;
        bp_mode = 0;
        k = 0;
        while (sbq.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        bit stale;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'(flags_o), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        issue(4'd4, 0, 0, 1, 8'h7F, 8'h01, 8'h00);
        check("add_result", 32'(result), 32'h80);
        check("add_wr_en", 32'(wr_en), 32'd1);
        check("add_flags", 32'(flags_o), 32'b0110);

        issue(4'd10, 0, 0, 0, 8'h05, 8'h05, 8'h00);
        check("cmp_wr_en", 32'(wr_en), 32'd0);
        check("cmp_flags", 32'(flags_o), 32'b1001);
        issue(4'd13, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        check("mov_flags_kept", 32'(flags_o), 32'b1001);

        issue(4'd2, 0, 0, 1, 8'h10, 8'h01, 8'h00);
        check("sub_result", 32'(result), 32'h0F);
        check("sub_flags", 32'(flags_o), 32'b1000);
        issue(4'd5, 0, 0, 0, 8'h01, 8'h01, 8'h00);
        check("adc_result", 32'(result), 32'h03);

        drain();
        bp_mode = 2;
        repeat (2) @(negedge clk);
        issue(4'd0, 1, 1, 1, 8'd13, 8'd11, 8'd2);
        cnt = 0;
        for (int k = 0; k < 100 && !out_valid; k++) begin
            @(negedge clk);
            if (!in_ready && !out_valid) cnt++;
        end
        check("mla_busy_cycles", 32'(cnt), 32'd8);
        check("mla_result", 32'(result), 32'h91);
        check("mla_flag_n", 32'(flags_o[FLAG_N]), 32'd1);
        check("mla_held_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        bp_mode = 0;
        repeat (2) @(negedge clk);
        check("mla_release_in_ready", 32'(in_ready), 32'd1);

        bp_mode = 1;
        repeat (300) begin
            issue(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), 1'($urandom),
                  1'($urandom), pick(), pick(), pick());
        end
        drain();

        issue(4'd0, 1, 0, 1, 8'd200, 8'd3, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        mflags = '0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_flags", 32'(flags_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        check("abort_no_stale", 32'(stale), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_flags_after", 32'(flags_o), 32'd0);

        issue(4'd4, 0, 0, 1, 8'd3, 8'd4, 8'd0);
        check("post_reset_add", 32'(result), 32'd7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the ARMv4 datapath. It executes all sixteen ARM data-processing opcodes plus MUL/MLA, and owns the architectural CNVZ flag register, including conditional update on the S bit. Operands enter through a valid/ready handshake and results leave through one. Single-cycle ops have 1-cycle latency. Multiplies run iteratively, one multiplier bit per cycle, while the block back-pressures the issue stage.

## Interface
- WIDTH, 32, datapath width; legal range 4..64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- op  in  4  ARM opcode: AND0 EOR1 SUB2 RSB3 ADD4 ADC5 SBC6 RSC7 TST8 TEQ9 CMP10 CMN11 ORR12 MOV13 BIC14 MVN15
- mul  in  1  1 = multiply; op ignored
- acc  in  1  with mul: MLA (add c)
- set_flags  in  1  S bit
- a, b, c  in  WIDTH  operands (MOV/MVN use b; c only for MLA)
- out_valid  out  1  result register valid
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  WIDTH  registered result
- wr_en  out  1  0 for TST/TEQ/CMP/CMN, else 1
- flags_o  out  4  flag register {C,N,V,Z} (bit3..bit0)

## Operation
- States: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Non-mul accept: result, wr_en and flags load at the accept edge. out_valid=1 at the next cycle. State stays IDLE.
- Mul accept: latch a, b, product = acc ? c : 0, cnt = 0, then go to MUL.
- In MUL, each edge: if b_shift[0] then product += a_shift. a_shift <<= 1, b_shift >>= 1, cnt++.
- On the edge where cnt reaches WIDTH-1: load result = product (mod 2^WIDTH), set out_valid, return to IDLE.
- Arithmetic uses a WIDTH+1-bit sum with no saturation:
  - SUB = a+~b+1, RSB = b+~a+1.
  - ADC = a+b+C, SBC = a+~b+C, RSC = b+~a+C.
  - CMP = SUB, CMN = ADD; both discard the result (wr_en=0).
- Carry-in C is the flag register value at the accept cycle.
- Flag update happens at the result-load edge:
  - TST/TEQ/CMP/CMN always update flags. Other ops update flags only if set_flags.
  - Arithmetic ops: C = carry out of bit WIDTH-1 (for subtracts, C = NOT borrow). V = operands' MSBs equal and result MSB differs, using the effective (possibly inverted) addend. N = result MSB. Z = result==0.
  - Logic/MOV/MVN/BIC/TST/TEQ and MUL/MLA: N and Z update; C and V hold.
- Flags are never modified outside a result-load edge.
- Back-to-back ops see the prior op's flags with no hazard, because flags update at the edge before the next accept.
- Output hold: while out_valid && !out_ready, result, wr_en and flags_o are stable, in_ready=0, and the state machine does not advance.
  - Mul completion therefore waits in IDLE-blocked fashion: a new mul is never accepted while a result is pending.
- out_valid clears on handshake unless a new non-mul op is accepted in the same cycle. In that case it stays 1 with the new result.

## Timing
- Reset (async assert, sync deassert at the source): state=IDLE, out_valid=0, result=0, wr_en=0, flags=0000, internal mul registers=0. in_ready=1 one cycle after deassert.
- Latency from accept edge to out_valid: non-mul 1 cycle; MUL/MLA WIDTH cycles. in_ready=0 throughout MUL.
- Throughput: 1 op/cycle for non-mul when out_ready=1.
- Reset asserted mid-multiply aborts the op: no result, flags 0000.
- in_valid while in_ready=0 is ignored. Inputs need not be held after accept.

## Structure
- Package alu_mc_pkg:
  - opcode enum (16 values above);
  - state enum {IDLE, MUL};
  - flag index constants FLAG_C=3, FLAG_N=2, FLAG_V=1, FLAG_Z=0;
  - function is_compare(op).
- Sub-module alu_mul_iter (WIDTH): start/a/b/c/acc in; done/product out; owns cnt and the shift registers.
- Adder, logic and flag logic live in alu_mc.

## Test plan
- Reset with WIDTH=8 -> out_valid=0, flags_o=0000, result=0x00; in_ready=1 after release.
- ADD a=0x7F b=0x01 S=1 -> next cycle result=0x80, wr_en=1, flags C0 N1 V1 Z0.
- CMP a=0x05 b=0x05 S=0 -> wr_en=0, flags C1 N0 V0 Z1. A following MOV b=0x00 S=0 leaves flags C1 Z1 unchanged.
- SUB 0x10-0x01 S=1 (C=1), then ADC 0x01+0x01 back-to-back -> results 0x0F then 0x03; the second op uses the first op's flags.
- MLA a=13 b=11 c=2, out_ready=0 for 3 cycles after completion:
  - in_ready=0 for 8 cycles;
  - result=0x91, N=1, stable while held;
  - handshake then in_ready=1.
- MUL accepted, rst_n pulsed low 3 cycles in -> out_valid=0, flags=0000, state IDLE; no stale result appears after release.
